// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for banked_data_memory
package dmem_pkg;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_RSV} mem_size_e;
  typedef enum logic {ST_INIT, ST_READY} dmem_state_e;
  function automatic logic [3:0] byte_en(mem_size_e size, logic [1:0] addr_lo);
    return size == MEM_B ? 4'b0001 << addr_lo :
           size == MEM_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
           size == MEM_W ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] lane_data(mem_size_e size, logic [31:0] wdata);
    return size == MEM_B ? {4{wdata[7:0]}} : size == MEM_H ? {2{wdata[15:0]}} : wdata;
  endfunction
  function automatic logic [31:0] load_ext(logic [31:0] word, mem_size_e size, logic [1:0] addr_lo, logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(word >> {addr_lo, 3'b000});
    h = addr_lo[1] ? word[31:16] : word[15:0];
    return size == MEM_B ? {{24{~uns & b[7]}}, b} :
           size == MEM_H ? {{16{~uns & h[15]}}, h} :
           size == MEM_W ? word : 32'h0;
  endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one byte lane, single write port and registered synchronous read
module dmem_bank #(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);
  logic [7:0] mem [DEPTH];
  // write and read share the address; a request is either a store or a load
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/banked_data_memory.sv
// banked_data_memory: 4-bank byte-addressable data memory, optional misalign trap via DMEM_MISALIGN_TRAP_EN
module banked_data_memory
  import dmem_pkg::*;
#(
  parameter int                DEPTH_WORDS    = 128,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              init_busy
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
  dmem_state_e state, state_n;
  logic [IW-1:0] cnt, widx, bank_addr;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W:0] span_end;
  logic [1:0] lo, rsp_lo;
  logic [3:0] be;
  logic [31:0] wlanes, rword;
  logic init_we, fire, err, misalign, rsp_load, rsp_uns;
  mem_size_e sz, rsp_size;
  assign sz = mem_size_e'(req_size);
  assign off = req_addr - BASE_ADDR;
  assign span_end = {1'b0, off} + (ADDR_W+1)'(sz == MEM_W ? 4 : sz == MEM_H ? 2 : 1);
  assign widx = off[IW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = (sz == MEM_H && off[0]) || (sz == MEM_W && off[1:0] != 2'b00);
  assign lo = off[1:0];
`else
  assign misalign = 1'b0;
  assign lo = sz == MEM_W ? 2'b00 : sz == MEM_H ? {off[1], 1'b0} : off[1:0];
`endif
  // request decode: range is checked on the raw byte span so nothing wraps past the top
  always_comb begin
    req_ready = state == ST_READY;
    init_busy = state == ST_INIT && CLEAR_ON_RESET;
    init_we = init_busy && !reset;
    fire = req_valid && req_ready && !reset;
    err = sz == MEM_RSV || span_end > LIMIT || misalign;
    be = (fire && req_write && !err) ? byte_en(sz, lo) : 4'b0000;
    wlanes = lane_data(sz, req_wdata);
    bank_addr = init_we ? cnt : widx;
    state_n = (state == ST_INIT && (!CLEAR_ON_RESET || cnt == IW'(DEPTH_WORDS - 1))) ? ST_READY : state;
  end
  // state register and clear-sweep counter
  always_ff @(posedge clk) begin
    state <= reset ? ST_INIT : state_n;
    cnt <= reset ? '0 : init_we ? cnt + 1'b1 : cnt;
  end
  for (genvar i = 0; i < 4; i++) begin : g_bank
    dmem_bank #(.DEPTH(DEPTH_WORDS)) u_bank (
      .clk  (clk),
      .we   (init_we | be[i]),
      .re   (fire),
      .addr (bank_addr),
      .wdata(init_we ? 8'h00 : wlanes[8*i +: 8]),
      .rdata(rword[8*i +: 8])
    );
  end
  // response pipeline stage; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_load <= 1'b0;
    end else begin
      rsp_valid <= fire;
      rsp_error <= fire && err;
      rsp_load <= fire && !req_write && !err;
    end
    rsp_size <= sz;
    rsp_lo <= lo;
    rsp_uns <= req_unsigned;
  end
  // extension applied after the synchronous bank read
  always_comb rsp_rdata = rsp_load ? load_ext(rword, rsp_size, rsp_lo, rsp_uns) : 32'h0;
endmodule
